// File: rtl/fifo_rd_stream.sv
// Read side of the async FIFO re-presented as a valid/ready stream through a 3-entry prefetch buffer.
// First word 2 cycles after FIFO goes non-empty, then 1 word/cycle; with m_ready low reads stop once 3 slots are claimed.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [1:0]            buf_level,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic [1:0]            occ;
  logic [1:0]            wptr;
  logic [1:0]            rptr;
  logic                  inflight;
  logic                  capture;
  logic                  pop;
  logic [2:0]            claimed;
  logic [FIFO_WIDTH-1:0] mem [3];

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read on the FIFO bus already owns a buffer slot, so it counts against the credit.
  assign claimed    = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = rst_n && !flush && !fifo_empty && (claimed < 3'd3);
  assign capture    = inflight && !flush;
  assign pop        = m_valid && m_ready && !flush;

  assign m_valid   = (occ != 2'd0);
  assign m_data    = mem[rptr];
  assign buf_level = occ;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      wptr     <= 2'd0;
      rptr     <= 2'd0;
      inflight <= 1'b0;
      xfer_cnt <= '0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else if (flush) begin
      occ      <= 2'd0;
      wptr     <= 2'd0;
      rptr     <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en && !fifo_empty;
      if (capture) begin
        mem[wptr] <= fifo_dout;
        wptr      <= ptr_inc(wptr);
      end
      if (pop) begin
        rptr     <= ptr_inc(rptr);
        xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
      end
      occ <= occ + {1'b0, capture} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream: behavioural FIFO plus an in-order word scoreboard.
module tb_fifo_rd_stream;

  logic        rd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_dout = 16'h0;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic [1:0]  buf_level;
  logic [15:0] xfer_cnt;

  // second instance with a narrow counter, fed from an always-non-empty source
  logic        rst4_n = 1'b0;
  logic        fifo_empty4 = 1'b1;
  logic [15:0] fifo_dout4 = 16'h5A5A;
  logic        fifo_rd_en4;
  logic        flush4 = 1'b0;
  logic        m_valid4;
  logic        m_ready4 = 1'b0;
  logic [15:0] m_data4;
  logic [1:0]  buf_level4;
  logic [3:0]  xfer_cnt4;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .buf_level(buf_level), .xfer_cnt(xfer_cnt)
  );

  fifo_rd_stream #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) dut4 (
    .rd_clk(rd_clk), .rst_n(rst4_n), .fifo_empty(fifo_empty4), .fifo_dout(fifo_dout4),
    .fifo_rd_en(fifo_rd_en4), .flush(flush4), .m_valid(m_valid4), .m_ready(m_ready4),
    .m_data(m_data4), .buf_level(buf_level4), .xfer_cnt(xfer_cnt4)
  );

  // Behavioural FIFO: a word read at posedge N is on fifo_dout during cycle N+1.
  logic [15:0] fmem [0:1023];
  int          wr_idx = 0;
  int          rd_idx = 0;
  int          rden_pulses = 0;

  assign fifo_empty = (wr_idx == rd_idx);

  always @(posedge rd_clk) begin
    if (fifo_rd_en) rden_pulses <= rden_pulses + 1;
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fmem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q [$];
  int          n_deliv = 0;
  logic        hold_pending = 1'b0;
  logic [15:0] hold_data = 16'h0;
  logic        capture_next = 1'b0;
  logic [15:0] first_after_flush = 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    fmem[wr_idx] = d;
    wr_idx       = wr_idx + 1;
    exp_q.push_back(d);
  endtask

  // One clock: drive inputs at negedge, check the pending handshake, advance to the next negedge.
  task automatic cycle(input logic rdy, input logic fl);
    logic [31:0] exp;
    m_ready = rdy;
    flush   = fl;
    #1;
    check("valid_vs_level", 32'(m_valid), 32'(buf_level != 2'd0));
    if (hold_pending) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(hold_data));
    end
    if (fl) check("flush_rden", 32'(fifo_rd_en), 32'd0);
    if (m_valid && m_ready && !flush) begin
      exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
      check("stream_data", 32'(m_data), exp);
      n_deliv++;
      if (capture_next) begin
        first_after_flush = m_data;
        capture_next      = 1'b0;
      end
    end
    hold_pending = m_valid && !m_ready && !flush;
    hold_data    = m_data;
    @(posedge rd_clk);
    @(negedge rd_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_p;
    int d_start;
    int pushed;
    int n_drop;
    int hs4;

    // reset held with data waiting in the FIFO
    push(16'h1234);
    repeat (3) @(negedge rd_clk);
    #1;
    check("rst_rden", 32'(fifo_rd_en), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(buf_level), 32'd0);
    check("rst_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    rst_n  = 1'b1;
    rst4_n = 1'b1;
    cycle(1'b0, 1'b0);
    check("lat_cycle1_valid", 32'(m_valid), 32'd0);
    cycle(1'b0, 1'b0);
    check("lat_cycle2_valid", 32'(m_valid), 32'd1);
    check("lat_cycle2_data", 32'(m_data), 32'h1234);
    cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);

    // streaming, no bubbles
    for (int i = 1; i <= 8; i++) push(16'(i));
    d_start = n_deliv;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("stream_no_bubble", 32'(m_valid), 32'd1);
      cycle(1'b1, 1'b0);
    end
    check("stream_done_valid", 32'(m_valid), 32'd0);
    check("stream_count", 32'(n_deliv - d_start), 32'd8);
    check("stream_xfer_cnt", 32'(xfer_cnt), 32'(16'(n_deliv)));

    // backpressure
    for (int i = 0; i < 6; i++) push(16'hA000 + 16'(i));
    base_p = rden_pulses;
    repeat (10) cycle(1'b0, 1'b0);
    check("bp_rden_pulses", 32'(rden_pulses - base_p), 32'd3);
    check("bp_level", 32'(buf_level), 32'd3);
    check("bp_head", 32'(m_data), 32'hA000);
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) cycle(1'b1, 1'b0);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) cycle(1'b1, 1'b0);
    check("bp_xfer_cnt", 32'(xfer_cnt), 32'(16'(n_deliv)));

    // random arrivals and random ready
    d_start = n_deliv;
    pushed  = 0;
    for (int it = 0; it < 5000 && (pushed < 200 || exp_q.size() > 0); it++) begin
      if (pushed < 200 && $urandom_range(0, 1) == 1) begin
        push(16'($urandom));
        pushed++;
      end
      cycle(1'($urandom_range(0, 1)), 1'b0);
    end
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_count", 32'(n_deliv - d_start), 32'd200);
    check("rand_xfer_cnt", 32'(xfer_cnt), 32'(16'(n_deliv)));
    repeat (3) cycle(1'b0, 1'b0);

    // flush with words buffered and one read on the FIFO bus
    for (int i = 0; i < 7; i++) push(16'hB000 + 16'(i));
    repeat (5) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("flush_pre_level", 32'(buf_level), 32'd2);
    capture_next = 1'b1;
    cycle(1'b1, 1'b1);
    check("flush_valid", 32'(m_valid), 32'd0);
    check("flush_level", 32'(buf_level), 32'd0);
    check("flush_no_count", 32'(xfer_cnt), 32'(16'(n_deliv)));
    // everything already pulled out of the FIFO but not delivered is gone
    n_drop = exp_q.size() - (wr_idx - rd_idx);
    for (int i = 0; i < n_drop; i++) void'(exp_q.pop_front());
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) cycle(1'b1, 1'b0);
    check("flush_drained", 32'(exp_q.size()), 32'd0);
    check("flush_next_word", 32'(first_after_flush), 32'hB004);
    repeat (2) cycle(1'b0, 1'b0);

    // narrow counter wraps
    fifo_empty4 = 1'b0;
    hs4 = 0;
    for (int i = 0; i < 200 && hs4 < 18; i++) begin
      m_ready4 = m_valid4;
      if (m_valid4) hs4++;
      @(posedge rd_clk);
      @(negedge rd_clk);
    end
    m_ready4    = 1'b0;
    fifo_empty4 = 1'b1;
    check("wrap_handshakes", 32'(hs4), 32'd18);
    check("wrap_xfer_cnt", 32'(xfer_cnt4), 32'd2);

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) push(16'hC000 + 16'(i));
    repeat (5) cycle(1'b0, 1'b0);
    check("pre_arst_level", 32'(buf_level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid), 32'd0);
    check("arst_level", 32'(buf_level), 32'd0);
    check("arst_cnt", 32'(xfer_cnt), 32'd0);
    check("arst_rden", 32'(fifo_rd_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
